// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 encoding constants for the instruction encoder.
//   - opcode and funct3 constants for the supported instruction classes
//   - canonical NOP word (addi x0,x0,0)
//   - kind_e: encoding of the in_kind field
package rv32_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_W   = 3'b010;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      KIND_ADD = 2'd0,
      KIND_LW  = 2'd1,
      KIND_SW  = 2'd2,
      KIND_BEQ = 2'd3
   } kind_e;

endpackage

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: input-field and output-word handshakes of the instruction encoder.
//   in_valid/in_ready   : field transfer (kind, rd, rs1, rs2, imm)
//   out_valid/out_ready : encoded word transfer (inst, addr, err)
// Modports:
//   master : producer of fields and consumer of words (testbench / boot loader)
//   slave  : the encoder
interface inst_encoder_if #(
   parameter int unsigned ADDR_W = 32
);

   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_kind;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [31:0]       in_imm;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;

   modport master (
      output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, out_err
   );

   modport slave (
      input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr, out_err
   );

endinterface

// File: rtl/inst_encoder_imm_pack.sv
// inst_encoder_imm_pack: combinational immediate placement and range check.
//   kind     in  instruction class
//   imm      in  signed byte offset
//   imm_bits out immediate bits at their instruction-word positions, zero elsewhere
//   legal    out immediate is representable for this kind (always 1 for ADD)
module inst_encoder_imm_pack
   import rv32_pkg::*;
(
   input  kind_e       kind,
   input  logic [31:0] imm,
   output logic [31:0] imm_bits,
   output logic        legal
);

   logic signed [31:0] simm;
   logic               fits_i;
   logic               fits_b;

   assign simm   = $signed(imm);
   assign fits_i = (simm >= -32'sd2048) && (simm <= 32'sd2047);
   // Branch offsets are halfword-aligned; the top legal even value is 4094.
   assign fits_b = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];

   always_comb begin
      imm_bits = '0;
      legal    = 1'b1;
      unique case (kind)
         KIND_ADD: begin
            legal = 1'b1;
         end
         KIND_LW: begin
            imm_bits[31:20] = imm[11:0];
            legal           = fits_i;
         end
         KIND_SW: begin
            imm_bits[31:25] = imm[11:5];
            imm_bits[11:7]  = imm[4:0];
            legal           = fits_i;
         end
         KIND_BEQ: begin
            // imm[0] is not stored; the core rebuilds the offset from imm[12:1].
            imm_bits[31]    = imm[12];
            imm_bits[30:25] = imm[10:5];
            imm_bits[11:8]  = imm[4:1];
            imm_bits[7]     = imm[11];
            legal           = fits_b;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: pipelined RV32 encoder for ADD / LW / SW / BEQ.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   bus       slave modport of inst_encoder_if (field input, word output)
//   err_count out  saturating count of error words accepted downstream
// One output register stage. Each accepted field set produces one word at the
// next sequential address; illegal immediates produce a NOP flagged out_err.
module inst_encoder
   import rv32_pkg::*;
#(
   parameter int unsigned          ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   inst_encoder_if.slave        bus,
   output logic [15:0]          err_count
);

   kind_e             kind;
   logic [31:0]       imm_bits;
   logic              legal;
   logic [31:0]       fields;
   logic [31:0]       enc_word;
   logic              in_fire;
   logic              out_fire;

   logic              out_valid_q;
   logic [31:0]       out_inst_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic              out_err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       err_count_q;

   assign kind = kind_e'(bus.in_kind);

   inst_encoder_imm_pack u_imm_pack (
      .kind     (kind),
      .imm      (bus.in_imm),
      .imm_bits (imm_bits),
      .legal    (legal)
   );

   // Register and opcode fields; immediate slots are left zero and OR-ed in below.
   always_comb begin
      fields = '0;
      unique case (kind)
         KIND_ADD: fields = {7'b0, bus.in_rs2, bus.in_rs1, F3_ADD, bus.in_rd, OP_R};
         KIND_LW:  fields = {12'b0, bus.in_rs1, F3_W, bus.in_rd, OP_LOAD};
         KIND_SW:  fields = {7'b0, bus.in_rs2, bus.in_rs1, F3_W, 5'b0, OP_STORE};
         KIND_BEQ: fields = {7'b0, bus.in_rs2, bus.in_rs1, F3_BEQ, 5'b0, OP_BRANCH};
         default:  fields = NOP;
      endcase
   end

   assign enc_word = legal ? (fields | imm_bits) : NOP;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign out_fire     = out_valid_q && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_inst_q  <= '0;
         out_addr_q  <= BASE_ADDR;
         out_err_q   <= 1'b0;
         addr_q      <= BASE_ADDR;
         err_count_q <= '0;
      end else begin
         if (in_fire) begin
            // A simultaneous output transfer is simply overwritten here.
            out_valid_q <= 1'b1;
            out_inst_q  <= enc_word;
            out_addr_q  <= addr_q;
            out_err_q   <= !legal;
            addr_q      <= addr_q + ADDR_W'(4);
         end else if (out_fire) begin
            out_valid_q <= 1'b0;
         end
         if (out_fire && out_err_q && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_inst  = out_inst_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_err   = out_err_q;
   assign err_count     = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: table-driven, scoreboarded bench for inst_encoder.
module tb_inst_encoder;
   import rv32_pkg::*;

   localparam int unsigned ADDR_W    = 32;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
   localparam int          NVEC      = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] err_count;

   inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   inst_encoder #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] addr;
      logic        err;
   } exp_t;

   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] inst;
      logic        err;
   } vec_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   vec_t        vec[NVEC];
   int          n_cmp     = 0;
   int          n_fail    = 0;
   int          err_model = 0;
   logic [31:0] exp_addr  = BASE_ADDR;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Core's B-type immediate generator: returns imm[12:1] sign-extended.
   function automatic logic [31:0] immgen_b(input logic [31:0] w);
      return {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
   endfunction

   // Scoreboard: compare every word accepted downstream against the queue head.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_word: got %h, want none", bus.out_inst);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_inst", bus.out_inst, mon_e.inst);
            check("out_addr", bus.out_addr, mon_e.addr);
            check("out_err", {31'b0, bus.out_err}, {31'b0, mon_e.err});
            if (mon_e.err) err_model++;
         end
      end
   end

   task automatic send(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [31:0] e_inst, input logic e_err, output int waits);
      logic rdy;
      bus.in_kind  = kind;
      bus.in_rd    = rd;
      bus.in_rs1   = rs1;
      bus.in_rs2   = rs2;
      bus.in_imm   = imm;
      bus.in_valid = 1'b1;
      waits        = 0;
      rdy          = 1'b0;
      while (1) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         waits++;
         if (rdy || waits >= 50) break;
      end
      if (rdy) begin
         exp_q.push_back('{inst: e_inst, addr: exp_addr, err: e_err});
         exp_addr = exp_addr + 32'd4;
      end else begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0, want 1 within 50 cycles");
      end
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain", {31'b0, (exp_q.size() != 0 || bus.out_valid)}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int total;
      int e0;
      logic [31:0] a0;

      vec[0]  = '{KIND_LW,  5'd5,  5'd2,  5'd0,  32'd8,          32'h0081_2283, 1'b0};
      vec[1]  = '{KIND_SW,  5'd0,  5'd1,  5'd6,  32'hFFFF_FFFC,  32'hFE60_AE23, 1'b0};
      vec[2]  = '{KIND_BEQ, 5'd0,  5'd1,  5'd2,  32'hFFFF_FFF8,  32'hFE20_8CE3, 1'b0};
      vec[3]  = '{KIND_LW,  5'd1,  5'd0,  5'd0,  32'hFFFF_F800,  32'h8000_2083, 1'b0};
      vec[4]  = '{KIND_SW,  5'd0,  5'd0,  5'd0,  32'd2047,       32'h7E00_2FA3, 1'b0};
      vec[5]  = '{KIND_BEQ, 5'd0,  5'd0,  5'd0,  32'd4094,       32'h7E00_0FE3, 1'b0};
      vec[6]  = '{KIND_BEQ, 5'd0,  5'd0,  5'd0,  32'hFFFF_F000,  32'h8000_0063, 1'b0};
      vec[7]  = '{KIND_ADD, 5'd31, 5'd31, 5'd31, 32'd5,          32'h01FF_8FB3, 1'b0};
      vec[8]  = '{KIND_LW,  5'd1,  5'd1,  5'd0,  32'd2048,       NOP,           1'b1};
      vec[9]  = '{KIND_BEQ, 5'd0,  5'd1,  5'd1,  32'd4096,       NOP,           1'b1};
      vec[10] = '{KIND_SW,  5'd0,  5'd1,  5'd1,  32'hFFFF_F7FF,  NOP,           1'b1};
      vec[11] = '{KIND_BEQ, 5'd0,  5'd1,  5'd2,  32'd5,          NOP,           1'b1};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_kind   = 2'd0;
      bus.in_rd     = 5'd0;
      bus.in_rs1    = 5'd0;
      bus.in_rs2    = 5'd0;
      bus.in_imm    = 32'd0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_out_inst", bus.out_inst, 32'd0);
      check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
      check("rst_out_addr", bus.out_addr, BASE_ADDR);
      check("rst_err_count", {16'b0, err_count}, 32'd0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table pass, back-to-back with out_ready high.
      total = 0;
      for (int i = 0; i < NVEC; i++) begin
         send(vec[i].kind, vec[i].rd, vec[i].rs1, vec[i].rs2, vec[i].imm,
              vec[i].inst, vec[i].err, w);
         total += w;
      end
      check("throughput_cycles", total, NVEC);
      drain();
      @(negedge clk);
      check("err_count_table", {16'b0, err_count}, 32'(err_model));
      check("err_count_table_n", {16'b0, err_count}, 32'd4);
      @(posedge clk);
      #1;

      // BEQ word decoded by the core's immediate generator.
      bus.out_ready = 1'b0;
      send(KIND_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0, w);
      @(negedge clk);
      check("immgen_beq", immgen_b(bus.out_inst), 32'hFFFF_FFFC);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();

      // Backpressure: ADD held for three cycles.
      bus.out_ready = 1'b0;
      send(KIND_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0, w);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
         check("bp_out_inst", bus.out_inst, 32'h0020_81B3);
         check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();

      // Illegal pair: two errors, address advances by 8.
      e0 = err_model;
      a0 = exp_addr;
      send(KIND_LW, 5'd1, 5'd2, 5'd0, 32'd2048, NOP, 1'b1, w);
      send(KIND_BEQ, 5'd0, 5'd1, 5'd2, 32'd5, NOP, 1'b1, w);
      drain();
      @(negedge clk);
      check("err_count_pair", {16'b0, err_count}, 32'(e0 + 2));
      check("addr_pair_last", bus.out_addr, a0 + 32'd4);
      @(posedge clk);
      #1;

      // Reset with a word in flight.
      bus.out_ready = 1'b0;
      send(KIND_ADD, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0010_80B3, 1'b0, w);
      @(negedge clk);
      check("pre_rst_out_valid", {31'b0, bus.out_valid}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_addr  = BASE_ADDR;
      err_model = 0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("post_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("post_rst_err_count", {16'b0, err_count}, 32'd0);
      @(posedge clk);
      #1;
      send(KIND_LW, 5'd5, 5'd2, 5'd0, 32'd8, 32'h0081_2283, 1'b0, w);
      drain();

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Pipelined RV32 instruction encoder for the four instruction classes the core supports (ADD, LW, SW, BEQ). It accepts decoded fields and a signed byte-offset immediate, and range-checks the immediate. It packs a 32-bit instruction word whose immediate bit placement is exactly what the core's immediate generator unpacks. Words stream out with a sequential instruction-memory address, so the block sits between the testbench or boot loader and the instruction-memory write port.

## Interface
- BASE_ADDR, 32'h0000_0000: address assigned to the first word after reset.
- ADDR_W, 32: width of out_addr.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- in_kind  in  2  0=ADD, 1=LW, 2=SW, 3=BEQ.
- in_rd, in_rs1, in_rs2  in  5 each  register indices; unused fields ignored per kind.
- in_imm  in  32  signed byte offset (LW/SW/BEQ); ignored for ADD.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  memory address of out_inst.
- out_err  out  1  word replaced by NOP due to illegal immediate.
- err_count  out  16  saturating count of accepted error words.

## Operation
- Encodings (funct7=0 where present):
  - ADD: {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}.
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}. imm[0] is dropped, so the immediate generator's 12-bit field is imm[12:1].
- Range rules:
  - LW/SW legal iff -2048 <= in_imm <= 2047.
  - BEQ legal iff -4096 <= in_imm <= 4094 and in_imm[0]==0.
  - ADD is always legal.
- Illegal immediate: out_inst = 32'h0000_0013 (addi x0,x0,0) and out_err = 1.
- The address still advances on an illegal word. err_count increments when that word is accepted downstream and saturates at 16'hFFFF.
- Single output register stage with valid/ready: in_ready = !out_valid || out_ready.
- An input transfer (in_valid && in_ready) loads out_inst, out_err and out_addr = addr_q, then sets out_valid.
- An output transfer (out_valid && out_ready) with no simultaneous input transfer clears out_valid.
- addr_q advances by 4 on each input transfer and wraps modulo 2^ADDR_W.
- Reset values: out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, err_count=0, addr_q=BASE_ADDR.

## Timing
- Latency: one cycle from input transfer to out_valid.
- Throughput: one word per cycle while out_ready is held high.
- Backpressure: out_valid=1 with out_ready=0 holds out_* stable and drives in_ready=0.
- Simultaneous input and output transfer: the new word replaces the old one and out_valid stays 1.
- rst has priority over any transfer in the same cycle. An in-flight word is discarded and the next accepted word gets BASE_ADDR.
- in_ready is combinational from out_valid and out_ready; there is no combinational path from in_* to out_*.

## Structure
- Shared package rv32_pkg:
  - opcode constants OP_R=7'b0110011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011.
  - funct3 constants F3_ADD/BEQ=3'b000, F3_W=3'b010; NOP constant 32'h0000_0013.
  - kind encoding KIND_ADD/LW/SW/BEQ.
- One combinational sub-module imm_pack(kind, imm -> imm_bits placed in a 32-bit mask, legal) isolates bit placement and range checks. The top level holds the registers, counters and handshake.

## Test plan
- After rst: send LW rd=5, rs1=2, imm=8 -> next cycle out_inst=32'h0081_2283, out_addr=0, out_err=0.
- Send SW rs2=6, rs1=1, imm=-4, then BEQ rs1=1, rs2=2, imm=-8 back-to-back with out_ready=1:
  - SW -> 32'hFE60_AE23 at addr 4.
  - BEQ -> 32'hFE20_8CE3 at addr 8.
  - Feed the BEQ word to the immediate generator and check it returns 32'hFFFF_FFFC.
- Send ADD rd=3, rs1=1, rs2=2 with out_ready=0 for 3 cycles -> out_inst=32'h0020_81B3 held stable, in_ready=0; accepted on the cycle out_ready rises.
- Illegal immediates:
  - LW imm=2048 -> out_inst=32'h0000_0013, out_err=1.
  - BEQ imm=5 -> out_inst=32'h0000_0013, out_err=1.
  - After both are accepted: err_count=2 and addr advanced by 8.
- Assert rst while out_valid=1 -> next cycle out_valid=0, err_count=0; next accepted word has out_addr=BASE_ADDR.
